// File: rtl/memd_arbiter_pkg.sv
// Shared definitions for the data-memory read-port arbiter: memory geometry,
// arbiter FSM state encoding and latency counter width.
package memd_arbiter_pkg;

  localparam int MEMD_SIZE_LOG = 12;
  localparam int REG_LEN       = 32;
  localparam int ARB_LAT_W     = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/memd_arbiter_rr_pick.sv
// Combinational round-robin priority picker: grants the first requesting
// index at or after rr_ptr, wrapping around. Also usable by the issue scheduler.
module memd_arbiter_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     grant
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W:0]   idx;

  // Scan N positions starting at rr_ptr and keep only the first hit.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      idx = (sum >= (PTR_W+1)'(N)) ? (sum - (PTR_W+1)'(N)) : sum;
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memd_arbiter.sv
// Shares the single data-memory read port between NUM_REQ load requesters.
// One access is outstanding at a time; a squashed owner still drains the
// fixed memory latency so no stale data can land in a later transaction.
module memd_arbiter
  import memd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MEM_LAT = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*MEMD_SIZE_LOG-1:0] req_addr,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               flush,
  output logic [NUM_REQ-1:0]               resp_valid,
  input  logic [NUM_REQ-1:0]               resp_ready,
  output logic [REG_LEN-1:0]               resp_data,
  output logic                             mem_en,
  output logic [MEMD_SIZE_LOG-1:0]         mem_addr,
  input  logic [REG_LEN-1:0]               mem_rdata,
  output logic                             busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_t               state;
  arb_state_t               state_nxt;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         owner;
  logic [MEMD_SIZE_LOG-1:0] addr_q;
  logic                     killed;
  logic [REG_LEN-1:0]       data_q;
  logic [ARB_LAT_W-1:0]     lat_cnt;

  logic [NUM_REQ-1:0]       cand;
  logic [NUM_REQ-1:0]       grant;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W-1:0]         next_ptr;
  logic                     owner_flush;
  logic                     owner_ready;
  logic                     lat_last;
  logic [MEMD_SIZE_LOG-1:0] req_addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign req_addr_arr[g] = req_addr[g*MEMD_SIZE_LOG +: MEMD_SIZE_LOG];
  end

  // A requester being squashed this cycle is never a candidate for a grant.
  assign cand        = req_valid & ~flush;
  assign owner_flush = flush[owner];
  assign owner_ready = resp_ready[owner];
  assign lat_last    = (lat_cnt == ARB_LAT_W'(1));

  memd_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (cand),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  // Convert the one-hot grant to an index and compute the wrapped successor.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
    next_ptr = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : (grant_idx + PTR_W'(1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: a kill seen on the last WAIT cycle still suppresses RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (|grant) state_nxt = ARB_ISSUE;
      ARB_ISSUE: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (lat_last) state_nxt = (killed || owner_flush) ? ARB_IDLE : ARB_RESP;
      ARB_RESP:  if (owner_flush || owner_ready) state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Transaction bookkeeping: owner/address latch, latency count, kill flag, read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      owner   <= '0;
      addr_q  <= '0;
      killed  <= 1'b0;
      data_q  <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|grant) begin
            owner  <= grant_idx;
            addr_q <= req_addr_arr[grant_idx];
            rr_ptr <= next_ptr;
            killed <= 1'b0;
          end
        end
        ARB_ISSUE: begin
          lat_cnt <= ARB_LAT_W'(MEM_LAT);
          if (owner_flush) killed <= 1'b1;
        end
        ARB_WAIT: begin
          lat_cnt <= lat_cnt - ARB_LAT_W'(1);
          if (owner_flush) killed <= 1'b1;
          if (lat_last) data_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Outputs: everything is zero unless qualified by the current state; grants are held off during reset.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    busy       = (state != ARB_IDLE);
    case (state)
      ARB_IDLE:  if (rst) req_ready = grant;
      ARB_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
      end
      ARB_RESP: begin
        resp_valid[owner] = 1'b1;
        resp_data         = data_q;
      end
      default: ;
    endcase
  end

endmodule
